// File: rtl/fir_tap_frontend.sv
// FIR tap front end: serial coefficient load, a NUM_TAPS-deep signed sample delay line
// and a registered per-tap product vector with a valid strobe for a downstream adder tree.
module fir_tap_frontend #(
    parameter int DATA_WIDTH    = 8,
    parameter int COEF_WIDTH    = 8,
    parameter int NUM_TAPS      = 53,
    parameter int PRODUCT_WIDTH = DATA_WIDTH + COEF_WIDTH
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                coef_load_start,
    input  logic                                coef_valid,
    input  logic signed [COEF_WIDTH-1:0]        coef_data,
    output logic                                coef_loaded,
    input  logic                                sample_valid,
    output logic                                sample_ready,
    input  logic signed [DATA_WIDTH-1:0]        sample_data,
    output logic [NUM_TAPS*PRODUCT_WIDTH-1:0]   products,
    output logic                                prod_valid
);

    localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] coef_index_reg;
    logic             coef_loaded_reg;
    logic             sample_ready_reg;
    logic             valid_pipe_reg;
    logic             prod_valid_reg;

    logic accept;
    logic coef_we;
    logic prod_load;

    // sample_ready_reg mirrors state_reg==S_RUN, so the handshake never loops back through inputs
    assign accept    = sample_valid & sample_ready_reg;
    assign coef_we   = (state_reg == S_LOAD) & coef_valid & ~coef_load_start;
    assign prod_load = valid_pipe_reg & ~coef_load_start;

    assign coef_loaded  = coef_loaded_reg;
    assign sample_ready = sample_ready_reg;
    assign prod_valid   = prod_valid_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= S_IDLE;
            coef_index_reg   <= '0;
            coef_loaded_reg  <= 1'b0;
            sample_ready_reg <= 1'b0;
            valid_pipe_reg   <= 1'b0;
            prod_valid_reg   <= 1'b0;
        end else begin
            valid_pipe_reg <= accept;
            prod_valid_reg <= valid_pipe_reg;
            if (coef_load_start) begin
                // Entering or restarting a load flushes anything still in flight
                state_reg        <= S_LOAD;
                coef_index_reg   <= '0;
                coef_loaded_reg  <= 1'b0;
                sample_ready_reg <= 1'b0;
                valid_pipe_reg   <= 1'b0;
                prod_valid_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        sample_ready_reg <= 1'b0;
                    end
                    S_LOAD: begin
                        if (coef_valid) begin
                            if (coef_index_reg == LAST_IDX) begin
                                state_reg        <= S_RUN;
                                coef_index_reg   <= '0;
                                coef_loaded_reg  <= 1'b1;
                                sample_ready_reg <= 1'b1;
                            end else begin
                                coef_index_reg <= coef_index_reg + IDX_W'(1);
                            end
                        end
                    end
                    S_RUN: begin
                        sample_ready_reg <= 1'b1;
                    end
                    default: begin
                        state_reg        <= S_IDLE;
                        coef_index_reg   <= '0;
                        coef_loaded_reg  <= 1'b0;
                        sample_ready_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            logic signed [COEF_WIDTH-1:0]    coef_reg;
            logic signed [DATA_WIDTH-1:0]    tap_reg;
            logic signed [DATA_WIDTH-1:0]    shift_in;
            logic signed [PRODUCT_WIDTH-1:0] prod_reg;
            logic signed [PRODUCT_WIDTH-1:0] prod_next;
            logic                            coef_sel;

            if (gi == 0) begin : g_head
                assign shift_in = sample_data;
            end else begin : g_body
                assign shift_in = g_tap[gi-1].tap_reg;
            end

            assign coef_sel = coef_we & (coef_index_reg == IDX_W'(gi));

            // Both operands sign-extended to full product width: -2^(D-1) * -2^(C-1) cannot wrap
            assign prod_next = $signed(PRODUCT_WIDTH'(tap_reg)) * $signed(PRODUCT_WIDTH'(coef_reg));

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    coef_reg <= '0;
                end else if (coef_sel) begin
                    coef_reg <= coef_data;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    tap_reg <= '0;
                end else if (coef_load_start) begin
                    tap_reg <= '0;
                end else if (accept) begin
                    tap_reg <= shift_in;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    prod_reg <= '0;
                end else if (prod_load) begin
                    prod_reg <= prod_next;
                end
            end

            assign products[gi*PRODUCT_WIDTH +: PRODUCT_WIDTH] = prod_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fir_tap_frontend.sv
// Bench for fir_tap_frontend: cycle model plus scoreboard queue of expected product
// vectors, a table of multiply corner vectors and hand-written load/reload sequences.
module tb_fir_tap_frontend;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int NT = 53;
    localparam int PW = DW + CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  resetn;
    logic                  coef_load_start;
    logic                  coef_valid;
    logic signed [CW-1:0]  coef_data;
    logic                  coef_loaded;
    logic                  sample_valid;
    logic                  sample_ready;
    logic signed [DW-1:0]  sample_data;
    logic [NT*PW-1:0]      products;
    logic                  prod_valid;

    fir_tap_frontend #(
        .DATA_WIDTH(DW),
        .COEF_WIDTH(CW),
        .NUM_TAPS(NT),
        .PRODUCT_WIDTH(PW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .coef_load_start(coef_load_start),
        .coef_valid(coef_valid),
        .coef_data(coef_data),
        .coef_loaded(coef_loaded),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_data(sample_data),
        .products(products),
        .prod_valid(prod_valid)
    );

    typedef struct {
        logic [NT*PW-1:0] prod;
        int               cyc;
    } exp_t;

    typedef struct {
        int c;
        int s;
        int exp;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_sum = 0;

    int m_state;
    int m_idx;
    bit m_loaded;
    int m_coef[NT];
    int m_tap[NT];
    int load_buf[NT];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_idx    = 0;
        m_loaded = 1'b0;
        for (int k = 0; k < NT; k++) begin
            m_coef[k] = 0;
            m_tap[k]  = 0;
        end
        sbq.delete();
    endtask

    task automatic idle_inputs();
        coef_load_start = 1'b0;
        coef_valid      = 1'b0;
        coef_data       = '0;
        sample_valid    = 1'b0;
        sample_data     = '0;
    endtask

    task automatic cmp_products(input logic [NT*PW-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int k = NT - 1; k >= 0; k--)
            if (products[k*PW +: PW] !== exp[k*PW +: PW]) bad = k;
        if (bad >= 0) begin
            errors++;
            $display("FAIL products[%0d] got %0d expected %0d (cycle %0d)", bad,
                     $signed(products[bad*PW +: PW]), $signed(exp[bad*PW +: PW]), cyc);
        end
    endtask

    // One clock cycle: observe outputs mid-cycle, advance the model by the edge, then step past it
    task automatic tick();
        exp_t e;
        logic [NT*PW-1:0] pv;
        int s;
        @(negedge clk);
        chk("sample_ready", longint'(sample_ready), longint'(m_state == 2));
        chk("coef_loaded", longint'(coef_loaded), longint'(m_loaded));
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL prod_valid_missing got 0 expected 1 at cycle %0d (now %0d)", sbq[0].cyc, cyc);
            e = sbq.pop_front();
        end
        if (prod_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL prod_valid_unexpected got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("prod_latency_cycle", longint'(cyc), longint'(e.cyc));
                cmp_products(e.prod);
            end
            s = 0;
            for (int k = 0; k < NT; k++) s += int'($signed(products[k*PW +: PW]));
            last_sum = s;
        end
        if (resetn) begin
            if (coef_load_start) begin
                m_state  = 1;
                m_idx    = 0;
                m_loaded = 1'b0;
                for (int k = 0; k < NT; k++) m_tap[k] = 0;
                while (sbq.size() > 0 && sbq[sbq.size()-1].cyc > cyc) e = sbq.pop_back();
            end else if (m_state == 1) begin
                if (coef_valid) begin
                    m_coef[m_idx] = int'(coef_data);
                    if (m_idx == NT - 1) begin
                        m_state  = 2;
                        m_loaded = 1'b1;
                        m_idx    = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (m_state == 2 && sample_valid) begin
                for (int k = NT - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
                m_tap[0] = int'(sample_data);
                for (int k = 0; k < NT; k++) pv[k*PW +: PW] = PW'(m_tap[k] * m_coef[k]);
                e.prod = pv;
                e.cyc  = cyc + 2;
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        cyc += 3;
        model_reset();
        resetn = 1'b1;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic write_coefs();
        for (int k = 0; k < NT; k++) begin
            coef_valid = 1'b1;
            coef_data  = CW'(load_buf[k]);
            tick();
        end
        coef_valid = 1'b0;
    endtask

    task automatic do_load();
        idle_inputs();
        coef_load_start = 1'b1;
        tick();
        coef_load_start = 1'b0;
        write_coefs();
    endtask

    task automatic push(input int s);
        sample_valid = 1'b1;
        sample_data  = DW'(s);
        tick();
        sample_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{c: -128, s: -128, exp: 16384};
        vecs[1] = '{c: -128, s:  127, exp: -16256};
        vecs[2] = '{c:  127, s:  127, exp: 16129};
        vecs[3] = '{c:  127, s: -128, exp: -16256};
        vecs[4] = '{c:   -1, s:   -1, exp: 1};
        vecs[5] = '{c:    5, s:   -3, exp: -15};
        vecs[6] = '{c:    0, s: -128, exp: 0};
        vecs[7] = '{c:   -7, s:    9, exp: -63};

        idle_inputs();
        resetn = 1'b0;
        do_reset();

        // Reset state; samples and coefficients offered in IDLE are ignored
        chk("reset_products_zero", longint'(|products), 0);
        chk("reset_sample_ready", longint'(sample_ready), 0);
        chk("reset_prod_valid", longint'(prod_valid), 0);
        sample_valid = 1'b1;
        sample_data  = 8'sd5;
        coef_valid   = 1'b1;
        coef_data    = 8'sd77;
        repeat (10) tick();
        idle_inputs();
        chk("idle_products_zero", longint'(|products), 0);

        // All-ones coefficients, 53 unit samples: last vector all ones, tree sum 53
        for (int k = 0; k < NT; k++) load_buf[k] = 1;
        do_load();
        chk("coef_loaded_after_last", longint'(coef_loaded), 1);
        sample_valid = 1'b1;
        sample_data  = 8'sd1;
        repeat (NT) tick();
        drain();
        chk("tree_sum_53", longint'(last_sum), 53);

        // Impulse of 2 walking through coef[k]=k+1
        for (int k = 0; k < NT; k++) load_buf[k] = k + 1;
        do_load();
        sample_valid = 1'b1;
        sample_data  = 8'sd2;
        tick();
        sample_data = 8'sd0;
        repeat (NT - 1) tick();
        drain();
        chk("impulse_last_product", longint'($signed(products[(NT-1)*PW +: PW])), 2 * NT);

        // Multiply corner table
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < NT; k++) load_buf[k] = vecs[v].c;
            do_load();
            push(vecs[v].s);
            drain();
            chk("corner_product", longint'($signed(products[PW-1:0])), longint'(vecs[v].exp));
            chk("corner_rest_zero", longint'(|products[NT*PW-1:PW]), 0);
        end

        // Load restart after 20 writes, with a sample offered during LOAD
        idle_inputs();
        coef_load_start = 1'b1;
        tick();
        coef_load_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            coef_valid = 1'b1;
            coef_data  = 8'sd9;
            tick();
        end
        coef_load_start = 1'b1;
        coef_data       = 8'sd99;
        sample_valid    = 1'b1;
        sample_data     = 8'sd33;
        tick();
        coef_load_start = 1'b0;
        for (int k = 0; k < NT - 1; k++) begin
            coef_valid = 1'b1;
            coef_data  = CW'(k - 26);
            if (k == 10) sample_valid = 1'b0;
            tick();
        end
        chk("coef_loaded_after_52", longint'(coef_loaded), 0);
        coef_data = CW'(NT - 1 - 26);
        tick();
        coef_valid = 1'b0;
        chk("coef_loaded_after_53", longint'(coef_loaded), 1);
        push(1);
        push(0);
        push(0);
        drain();
        chk("restart_coef0", longint'($signed(products[PW-1:0])), 0);
        chk("restart_coef2", longint'($signed(products[2*PW +: PW])), -24);

        // Reload from RUN in the same cycle as a sample
        push(3);
        drain();
        coef_load_start = 1'b1;
        sample_valid    = 1'b1;
        sample_data     = 8'sd55;
        tick();
        idle_inputs();
        tick();
        chk("reload_ready_low", longint'(sample_ready), 0);
        for (int k = 0; k < NT; k++) load_buf[k] = 1;
        write_coefs();
        push(4);
        drain();
        chk("reload_tap0", longint'($signed(products[PW-1:0])), 4);
        chk("reload_tap1_flushed", longint'($signed(products[PW +: PW])), 0);

        // Reset mid-operation
        push(7);
        do_reset();
        chk("midreset_products_zero", longint'(|products), 0);
        chk("midreset_coef_loaded", longint'(coef_loaded), 0);
        sample_valid = 1'b1;
        sample_data  = 8'sd1;
        repeat (4) tick();
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_tap_frontend.md
Name: fir_tap_frontend

Overview:
- Producer side of the adder-tree interface.
- Accepts a serial stream of signed samples into a NUM_TAPS-deep delay line and multiplies each tap by a stored coefficient.
- Presents the registered product vector, with a valid strobe, to the pipelined addertree, which sums it.
- Coefficients are loaded serially through a small load state machine before filtering starts.

Parameters:
- DATA_WIDTH, 8, signed sample width.
- COEF_WIDTH, 8, signed coefficient width.
- NUM_TAPS, 53, number of taps; matches addertree NUM_INPUTS.
- PRODUCT_WIDTH, DATA_WIDTH+COEF_WIDTH (16), width of each product; matches addertree INPUT_WIDTH.

Ports:
- clk, in, 1, single clock, rising edge.
- resetn, in, 1, reset: asynchronous, active-low.
- coef_load_start, in, 1, one-cycle pulse that starts or restarts a coefficient load.
- coef_valid, in, 1, coef_data is valid this cycle.
- coef_data, in, COEF_WIDTH, signed coefficient, written in order tap 0 to tap NUM_TAPS-1.
- coef_loaded, out, 1, high once a full coefficient set is loaded.
- sample_valid, in, 1, sample_data is valid.
- sample_ready, out, 1, block accepts a sample.
- sample_data, in, DATA_WIDTH, signed input sample.
- products, out, NUM_TAPS x PRODUCT_WIDTH, signed; products[k] = tap[k]*coef[k]; packed like addertree inputd.
- prod_valid, out, 1, products holds a new result this cycle.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, coef_index=0.
  - All coefficients, taps and products = 0.
  - prod_valid=0, coef_loaded=0, sample_ready=0.
- States: IDLE, LOAD, RUN.
- sample_ready = (state==RUN), registered from state only; it never depends combinationally on inputs.
- IDLE:
  - coef_load_start -> LOAD.
  - coef_valid and sample_valid are ignored.
- LOAD:
  - On entry: coef_index=0, all taps cleared to 0, valid pipeline cleared, coef_loaded=0.
  - Each cycle with coef_valid=1: coef[coef_index]=coef_data, coef_index++.
  - Write with coef_index==NUM_TAPS-1 -> RUN and coef_loaded=1 on the next edge.
  - coef_load_start while in LOAD (even together with coef_valid): restart at coef_index=0. The coef_data in that cycle is discarded. Previously written coefficients remain until overwritten.
- RUN:
  - Sample handshake = sample_valid && sample_ready.
  - On a handshake: tap[0]=sample_data and tap[k]=tap[k-1] for k=1..NUM_TAPS-1. The oldest sample drops off.
  - coef_valid is ignored.
  - coef_load_start -> LOAD. A sample handshaken in the same cycle is shifted in and then cleared by the LOAD entry flush. Any pending prod_valid for it is suppressed.
- Pipeline:
  - Cycle N: handshake; taps update at the edge ending N.
  - Cycle N+1: products[k] registered from tap[k]*coef[k] (full-precision signed multiply, no truncation or saturation).
  - prod_valid=1 during cycle N+2 for exactly one cycle per accepted sample.
  - Back-to-back samples give back-to-back prod_valid.
  - products holds its last value while prod_valid=0.
- No downstream backpressure: the addertree always accepts.
- Width rule: PRODUCT_WIDTH = DATA_WIDTH+COEF_WIDTH, so -2^(D-1) * -2^(C-1) fits without overflow.
- Reset mid-operation: returns immediately to the reset state. All coefficients are lost and a new load is required.

Test Plan:
- Reset, then hold sample_valid=1 -> sample_ready=0, prod_valid never asserts, products all 0.
- Load 53 coefs of 1, then push 53 samples of value 1 -> coef_loaded=1 one cycle after the last coef. The 53rd prod_valid shows every products[k]=1, and the downstream addertree sum is 53.
- Coefs coef[k]=k+1, one sample 2 followed by zeros -> the prod_valid after the j-th push (j=1..53) shows products[j-1]=2*j and all other products 0. prod_valid lags each handshake by 2 cycles.
- Corners: coef=-128 with sample=-128 gives product 16384; coef=-128 with sample 127 gives -16256; no wrap.
- Pulse coef_load_start after 20 coef writes -> coef_index restarts. 53 further writes are needed before RUN. A sample given during LOAD is not accepted.
- Assert coef_load_start in RUN in the same cycle as a sample -> no prod_valid for that sample, taps read 0 after reload, sample_ready=0 until the reload completes.
